compressed_stream_packer: RTL

//  Downstream neighbour of the eight-word compress unit. Takes one compressed block record per

---
 rtl/compressed_stream_packer_if.sv | 41 ++++
 rtl/compressed_stream_packer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/compressed_stream_packer_if.sv
// Record-in / packed-word-out bundle for compressed_stream_packer.
// PACKER_STATS_EN adds the statRecords/statBytes counters to the bundle.
interface compressed_stream_packer_if #(
   parameter int unsigned DATA_WORDS = 8,
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned TAG_W      = 2,
   parameter int unsigned OUT_W      = 256
);
   logic                               validIn;
   logic                               readyIn;
   logic [DATA_WORDS*WORD_W-1:0]       dataIn;
   logic [DATA_WORDS*TAG_W-1:0]        tagIn;
   logic [7:0]                         lenIn;
   logic                               flushIn;
   logic [OUT_W-1:0]                   dataOut;
   logic [$clog2(OUT_W/8+1)-1:0]       bytesOut;
   logic                               lastOut;
   logic                               validOut;
   logic                               readyOut;
   logic                               errOut;
`ifdef PACKER_STATS_EN
   logic [31:0]                        statRecords;
   logic [31:0]                        statBytes;
`endif

   modport master (
      output validIn, dataIn, tagIn, lenIn, flushIn, readyOut,
      input  readyIn, dataOut, bytesOut, lastOut, validOut, errOut
`ifdef PACKER_STATS_EN
      , input statRecords, statBytes
`endif
   );

   modport slave (
      input  validIn, dataIn, tagIn, lenIn, flushIn, readyOut,
      output readyIn, dataOut, bytesOut, lastOut, validOut, errOut
`ifdef PACKER_STATS_EN
      , output statRecords, statBytes
`endif
   );
endinterface

// File: rtl/compressed_stream_packer.sv
// Packs {tag, payload} compressed block records into a gap-free stream of full output words.
// Optional feature macro: PACKER_STATS_EN (record / emitted-byte counters).
module compressed_stream_packer #(
   parameter int unsigned DATA_WORDS = 8,
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned TAG_W      = 2,
   parameter int unsigned OUT_W      = 256
) (
   input logic                      clk,
   input logic                      reset,
   compressed_stream_packer_if.slave bus
);
   localparam int unsigned PayBytes = DATA_WORDS * WORD_W / 8;
   localparam int unsigned TagBytes = DATA_WORDS * TAG_W / 8;
   localparam int unsigned OutBytes = OUT_W / 8;
   localparam int unsigned BufBytes = 2 * OutBytes;
   localparam int unsigned RecBytes = TagBytes + PayBytes;
   localparam int unsigned FillW    = $clog2(BufBytes + 1);
   localparam int unsigned BytesW   = $clog2(OutBytes + 1);

   localparam logic [FillW-1:0] OutBytesF = FillW'(OutBytes);
   localparam logic [FillW-1:0] TagBytesF = FillW'(TagBytes);
   localparam logic [FillW-1:0] PayBytesF = FillW'(PayBytes);
   // Largest fill at which a maximum-size record still fits in the buffer.
   localparam logic [FillW-1:0] AcceptMax = FillW'(BufBytes - RecBytes);

   logic [BufBytes*8-1:0] buf_q, buf_d, shifted;
   logic [RecBytes*8-1:0] rec;
   logic [FillW-1:0]      fill_q, fill_d, fill_base, len_eff;
   logic                  flush_pend_q, flush_pend_d;
   logic                  run_q;
   logic                  err_q, err_d;
   logic                  full_word, partial_word, valid_out, ready_in;
   logic                  drain, accept, len_over;
   logic [BytesW-1:0]     bytes_out;

   always_comb begin
      full_word    = fill_q >= OutBytesF;
      partial_word = flush_pend_q && (fill_q != '0) && !full_word;
      valid_out    = full_word || partial_word;
      ready_in     = run_q && !flush_pend_q && (fill_q <= AcceptMax);
      bytes_out    = full_word ? BytesW'(OutBytes) :
                     (partial_word ? fill_q[BytesW-1:0] : '0);
      drain        = valid_out && bus.readyOut;
      accept       = bus.validIn && ready_in;
      len_over     = bus.lenIn > 8'(PayBytes);
      len_eff      = len_over ? PayBytesF : FillW'(bus.lenIn);
   end

   assign bus.validOut = valid_out;
   assign bus.readyIn  = ready_in;
   assign bus.lastOut  = partial_word;
   assign bus.bytesOut = bytes_out;
   // Bytes above fill are kept zero, so a partial word needs no masking here.
   assign bus.dataOut  = buf_q[OUT_W-1:0];
   assign bus.errOut   = err_q;

   always_comb begin
      rec = '0;
      rec[TagBytes*8-1:0] = bus.tagIn;
      for (int k = 0; k < PayBytes; k++) begin
         if (FillW'(k) < len_eff) rec[(TagBytes+k)*8 +: 8] = bus.dataIn[k*8 +: 8];
      end
   end

   // Drain is applied before append so a same-cycle record lands at the post-shift offset.
   always_comb begin
      shifted   = buf_q;
      fill_base = fill_q;
      if (drain) begin
         if (full_word) begin
            shifted   = buf_q >> OUT_W;
            fill_base = fill_q - OutBytesF;
         end else begin
            shifted   = '0;
            fill_base = '0;
         end
      end
      buf_d  = shifted;
      fill_d = fill_base;
      if (accept) begin
         buf_d  = shifted | ({{((BufBytes-RecBytes)*8){1'b0}}, rec} << {fill_base, 3'b000});
         fill_d = fill_base + TagBytesF + len_eff;
      end
   end

   always_comb begin
      flush_pend_d = flush_pend_q;
      if (flush_pend_q) begin
         if ((fill_q == '0) || (drain && partial_word)) flush_pend_d = 1'b0;
      end else if (bus.flushIn) begin
         flush_pend_d = 1'b1;
      end
      err_d = err_q | (accept && len_over);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_q        <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         run_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         buf_q        <= buf_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         run_q        <= 1'b1;
         err_q        <= err_d;
      end
   end

`ifdef PACKER_STATS_EN
   logic [31:0] stat_records_q, stat_bytes_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stat_records_q <= '0;
         stat_bytes_q   <= '0;
      end else begin
         if (accept) stat_records_q <= stat_records_q + 32'd1;
         if (drain)  stat_bytes_q   <= stat_bytes_q + 32'(bytes_out);
      end
   end

   assign bus.statRecords = stat_records_q;
   assign bus.statBytes   = stat_bytes_q;
`endif
endmodule
